// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Receive-side PWM measurement. Synchronises an asynchronous PWM line,
// measures the rising-edge-to-rising-edge period and the high time of each
// complete period, and reports a normalised duty value in the same
// 0 .. 2^DUTY_W-1 scale the servo PWM generator accepts.
//
// A line that shows no edge for TIMEOUT cycles is flagged as stuck. The duty
// output is then forced to the rail the line is stuck at.
//
// Parameters
//   CNT_W    width of the cycle counters and of period_cycles/high_cycles
//   DUTY_W   width of the duty output; full scale is 2^DUTY_W
//   TIMEOUT  cycles without an edge before the line is declared stuck
//
// Ports
//   clk            board clock, all logic on its rising edge
//   reset          synchronous, active-high reset
//   pwm_in         asynchronous PWM input
//   period_cycles  clocks between consecutive rising edges (last accepted)
//   high_cycles    clocks the line was high within that period
//   duty           floor(high_cycles * 2^DUTY_W / period_cycles)
//   valid          one-cycle pulse when the three measurements update
//   stuck          level, set on timeout, cleared by the next valid
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DUTY_W  = 10,
  parameter int unsigned TIMEOUT = 4_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cycles,
  output logic [CNT_W-1:0]  high_cycles,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BIT_W  = $clog2(DUTY_W + 1);

  localparam logic [IDLE_W-1:0] IDLE_SAT   = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  // Shortest period that still leaves the divider DUTY_W cycles to finish
  // before the following period can complete.
  localparam logic [CNT_W-1:0]  MIN_PERIOD = CNT_W'(DUTY_W + 2);
  localparam logic [BIT_W-1:0]  DIV_STEPS  = BIT_W'(DUTY_W);
  localparam logic [BIT_W-1:0]  DIV_ONE    = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Input conditioning
  logic r_sync1;
  logic r_pwm_s;
  logic r_pwm_d;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  // Timeout
  logic [IDLE_W-1:0] r_idle;
  logic              w_timeout;

  // Period / high-time measurement
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_load;

  // Restoring divider
  logic              r_div_busy;
  logic [BIT_W-1:0]  r_div_bits;
  logic [CNT_W-1:0]  r_div_rem;
  logic [CNT_W-1:0]  r_div_den;
  logic [CNT_W-1:0]  r_div_high;
  logic [DUTY_W-1:0] r_div_quo;
  logic [CNT_W:0]    w_rem_shift;
  logic [CNT_W:0]    w_rem_diff;
  logic              w_rem_ge;
  logic [CNT_W-1:0]  w_rem_next;
  logic [DUTY_W-1:0] w_quo_next;
  logic              w_div_last;

  // Output registers
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_stuck;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser plus one delay flop for edge detection.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_pwm_s <= 1'b0;
      r_pwm_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge
      // input; blocking ones here would collapse the chain into one flop.
      r_sync1 <= pwm_in;
      r_pwm_s <= r_sync1;
      r_pwm_d <= r_pwm_s;
    end
  end

  assign w_rise = r_pwm_s & ~r_pwm_d;
  assign w_fall = ~r_pwm_s & r_pwm_d;
  assign w_edge = w_rise | w_fall;

  // -------------------------------------------------------------------------
  // Idle counter: cleared by any edge, otherwise counts up and parks at
  // TIMEOUT so the timeout event fires exactly once per quiet stretch.
  // An edge in the cycle the counter would reach TIMEOUT wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_edge) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_SAT) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  assign w_timeout = ~w_edge & (r_idle == IDLE_LAST);

  // Saturating period counter; it never wraps back to a small value.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // A completed period that is long enough starts a divide.
  assign w_load = (r_state == S_LOW) & w_rise & (r_cnt >= MIN_PERIOD);

  // -------------------------------------------------------------------------
  // One restoring-division step. The numerator is high << DUTY_W; because
  // high < period, its top CNT_W bits are already a valid partial remainder,
  // so the divider starts with remainder = high and shifts in DUTY_W zeros.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: each signal is assigned on every path through this block, so no
    // latch can be inferred.
    w_rem_shift = {r_div_rem, 1'b0};
    w_rem_diff  = w_rem_shift - {1'b0, r_div_den};
    // No borrow out of the subtraction means shifted remainder >= divisor.
    w_rem_ge    = ~w_rem_diff[CNT_W];
    w_rem_next  = w_rem_ge ? w_rem_diff[CNT_W-1:0] : w_rem_shift[CNT_W-1:0];
    w_quo_next  = {r_div_quo[DUTY_W-2:0], w_rem_ge};
    w_div_last  = (r_div_bits == DIV_ONE);
  end

  // -------------------------------------------------------------------------
  // Measurement FSM, divider sequencing and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi_lat   <= '0;
      r_div_busy <= 1'b0;
      r_div_bits <= '0;
      r_div_rem  <= '0;
      r_div_den  <= '0;
      r_div_high <= '0;
      r_div_quo  <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_duty     <= '0;
      r_valid    <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          // The first rise only starts timing; that partial period is
          // never reported.
          if (w_rise) begin
            r_cnt   <= CNT_ONE;
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          r_cnt <= w_cnt_inc;
          if (w_fall) begin
            r_hi_lat <= r_cnt;
            r_state  <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            // Period complete; short ones are dropped but timing restarts.
            r_cnt   <= CNT_ONE;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_timeout) begin
        // Abandon any in-flight divide; period and high time keep their
        // last reported values, duty goes to the rail the line sits at.
        r_state    <= S_IDLE;
        r_div_busy <= 1'b0;
        r_stuck    <= 1'b1;
        r_duty     <= r_pwm_s ? {DUTY_W{1'b1}} : '0;
      end else begin
        if (r_div_busy) begin
          r_div_rem  <= w_rem_next;
          r_div_quo  <= w_quo_next;
          r_div_bits <= r_div_bits - DIV_ONE;
          if (w_div_last) begin
            r_div_busy <= 1'b0;
            r_valid    <= 1'b1;
            r_stuck    <= 1'b0;
            r_duty     <= w_quo_next;
            r_period   <= r_div_den;
            r_high     <= r_div_high;
          end
        end
        // The minimum-period rule guarantees the previous divide has
        // finished before the next load.
        if (w_load) begin
          r_div_busy <= 1'b1;
          r_div_bits <= DIV_STEPS;
          r_div_rem  <= r_hi_lat;
          r_div_den  <= r_cnt;
          r_div_high <= r_hi_lat;
          r_div_quo  <= '0;
        end
      end
    end
  end

  assign period_cycles = r_period;
  assign high_cycles   = r_high;
  assign duty          = r_duty;
  assign valid         = r_valid;
  assign stuck         = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives directed and random PWM waveforms into pwm_capture (TIMEOUT reduced
// to 5000) and compares every output on every cycle against a timestamp
// model: rises and falls of the synchronised line are timestamped, each
// accepted period becomes a queued result that is due DUTY_W cycles after
// its closing rise, and quiet stretches of TIMEOUT cycles raise stuck.
// Literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W   = 32;
  localparam int DUTY_W  = 10;
  localparam int TIMEOUT = 5000;

  logic              clk;
  logic              reset;
  logic              pwm_in;
  logic [CNT_W-1:0]  period_cycles;
  logic [CNT_W-1:0]  high_cycles;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              stuck;

  pwm_capture #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .duty         (duty),
    .valid        (valid),
    .stuck        (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    longint due;
    longint per;
    longint hi;
  } meas_t;

  meas_t  pend[$];
  longint cyc        = 0;
  longint last_edge  = 0;
  longint last_rise  = 0;
  longint last_fall  = 0;
  bit     armed      = 1'b0;
  bit     seen_reset = 1'b0;
  logic [2:0] hist   = 3'b000;   // [0] newest pwm_in sample

  longint exp_period = 0;
  longint exp_high   = 0;
  longint exp_duty   = 0;
  bit     exp_valid  = 1'b0;
  bit     exp_stuck  = 1'b0;

  longint last_in_rise   = 0;
  longint last_valid_cyc = 0;
  logic   prev_in        = 1'b0;
  int     valid_cnt      = 0;

  always @(posedge clk) begin
    logic ps, pd, rise, fall;
    meas_t m;
    cyc++;
    if (pwm_in === 1'b1 && prev_in !== 1'b1) last_in_rise = cyc;
    prev_in = pwm_in;

    if (reset === 1'b1) begin
      seen_reset = 1'b1;
      exp_period = 0;
      exp_high   = 0;
      exp_duty   = 0;
      exp_valid  = 1'b0;
      exp_stuck  = 1'b0;
      armed      = 1'b0;
      pend.delete();
      last_edge  = cyc;
      hist       = 3'b000;
    end else if (seen_reset) begin
      // Line as seen after the synchroniser: sample taken two edges ago.
      ps   = hist[1];
      pd   = hist[2];
      rise = ps & ~pd;
      fall = ~ps & pd;
      exp_valid = 1'b0;

      if (!rise && !fall && (cyc - last_edge == TIMEOUT)) begin
        exp_stuck = 1'b1;
        exp_duty  = ps ? ((64'sd1 << DUTY_W) - 1) : 0;
        armed     = 1'b0;
        pend.delete();
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
        m          = pend.pop_front();
        exp_valid  = 1'b1;
        exp_stuck  = 1'b0;
        exp_period = m.per;
        exp_high   = m.hi;
        exp_duty   = (m.hi * (64'sd1 << DUTY_W)) / m.per;
      end

      if (rise || fall) last_edge = cyc;
      if (fall) last_fall = cyc;
      if (rise) begin
        if (armed && (cyc - last_rise >= DUTY_W + 2)) begin
          m.due = cyc + DUTY_W;
          m.per = cyc - last_rise;
          m.hi  = last_fall - last_rise;
          pend.push_back(m);
        end
        last_rise = cyc;
        armed     = 1'b1;
      end
      hist = {hist[1:0], pwm_in};
    end
  end

  // Compare process: outputs checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      check("cyc_valid",  64'(valid),         64'(exp_valid));
      check("cyc_stuck",  64'(stuck),         64'(exp_stuck));
      check("cyc_duty",   64'(duty),          exp_duty);
      check("cyc_period", 64'(period_cycles), exp_period);
      check("cyc_high",   64'(high_cycles),   exp_high);
      if (valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic drive_level(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs(input string tag, input longint per,
                               input longint hi, input longint dt);
    check({tag, "_period"}, 64'(period_cycles), per);
    check({tag, "_high"},   64'(high_cycles),   hi);
    check({tag, "_duty"},   64'(duty),          dt);
  endtask

  int v0;

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0);
    check("reset_valid", 64'(valid), 0);
    check("reset_stuck", 64'(stuck), 0);
    reset = 1'b0;
    drive_level(1'b0, 50);

    // Basic: four 1000/250 periods, then the start of a fifth.
    v0 = valid_cnt;
    repeat (4) begin
      drive_level(1'b1, 250);
      drive_level(1'b0, 750);
    end
    drive_level(1'b1, 20);
    check("basic_count", 64'(valid_cnt - v0), 4);
    check_outputs("basic", 1000, 250, 256);
    // valid is visible between edges k+DUTY_W+2 and k+DUTY_W+3, where k is
    // the edge that first samples pwm_in high.
    check("basic_latency", 64'(last_valid_cyc - last_in_rise), DUTY_W + 2);
    drive_level(1'b1, 230);
    drive_level(1'b0, 750);

    // Extreme duty.
    drive_level(1'b1, 999);
    drive_level(1'b0, 1);
    drive_level(1'b1, 1);
    drive_level(1'b0, 20);
    check_outputs("duty_max", 1000, 999, 1022);
    drive_level(1'b0, 979);
    drive_level(1'b1, 20);
    check_outputs("duty_min", 1000, 1, 1);
    check("duty_min_stuck", 64'(stuck), 0);
    drive_level(1'b1, 230);
    drive_level(1'b0, 750);

    // Glitch: a 6-cycle period between two normal ones.
    v0 = valid_cnt;
    drive_level(1'b1, 3);
    drive_level(1'b0, 3);
    drive_level(1'b1, 250);
    drive_level(1'b0, 750);
    drive_level(1'b1, 20);
    check("glitch_count", 64'(valid_cnt - v0), 2);
    check_outputs("glitch", 1000, 250, 256);
    drive_level(1'b1, 230);
    drive_level(1'b0, 750);

    // Random periods, including some below the glitch threshold.
    for (int i = 0; i < 40; i++) begin
      int per;
      int hi;
      if ($urandom_range(0, 7) == 0) per = int'($urandom_range(2, 11));
      else                           per = int'($urandom_range(12, 400));
      hi = int'($urandom_range(1, per - 1));
      drive_level(1'b1, hi);
      drive_level(1'b0, per - hi);
    end

    // Stuck high after a valid 1000/250 period.
    drive_level(1'b1, 250);
    drive_level(1'b0, 750);
    drive_level(1'b1, 20);
    v0 = valid_cnt;
    drive_level(1'b1, 5980);
    check("stuck_set", 64'(stuck), 1);
    check("stuck_novalid", 64'(valid_cnt - v0), 0);
    check_outputs("stuck", 1000, 250, 1023);
    drive_level(1'b0, 500);
    drive_level(1'b1, 500);
    drive_level(1'b0, 500);
    check("stuck_hold", 64'(stuck), 1);
    drive_level(1'b1, 20);
    check_outputs("restart", 1000, 500, 512);
    check("restart_stuck", 64'(stuck), 0);
    drive_level(1'b1, 480);
    drive_level(1'b0, 500);

    // Reset during the high phase.
    drive_level(1'b1, 100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("midrst", 0, 0, 0);
    check("midrst_valid", 64'(valid), 0);
    check("midrst_stuck", 64'(stuck), 0);
    reset = 1'b0;
    drive_level(1'b1, 149);
    drive_level(1'b0, 750);
    drive_level(1'b1, 250);
    drive_level(1'b0, 750);
    drive_level(1'b1, 20);
    check_outputs("postrst", 1000, 250, 256);

    // Rise arriving in the very cycle the timeout would fire: rise wins.
    drive_level(1'b1, 230);
    drive_level(1'b0, TIMEOUT);
    drive_level(1'b1, 20);
    check("coinc_stuck", 64'(stuck), 0);
    check_outputs("coinc", 5250, 250, 48);

    // One cycle later the timeout fires first.
    drive_level(1'b1, 230);
    drive_level(1'b0, TIMEOUT + 1);
    drive_level(1'b1, 20);
    check("late_stuck", 64'(stuck), 1);
    check_outputs("late", 5250, 250, 0);
    drive_level(1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: got timeout at t=%0t, expected end of stimulus", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
